// File: rtl/array_divider.sv
// ============================================================================
// Module   : array_divider
// Purpose  : 16/8 unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_divider #(
  parameter logic [3:0] INSTANCE_ID = 4'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [15:0] Z,
  input  logic [7:0]  B,
  output logic [7:0]  A_final,
  output logic [7:0]  R_final,
  output logic        ovf,
  output logic        dbz,
  output logic        o_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [8:0]  r_rem;
  logic [15:0] r_quot;
  logic [4:0]  r_cnt;
  logic [7:0]  r_b_q;
  logic [7:0]  r_a_final;
  logic [7:0]  r_r_final;
  logic        r_ovf;
  logic        r_dbz;

  logic        w_accept;
  logic        w_last;
  logic [8:0]  w_rem_sh;
  logic        w_ge;
  logic [8:0]  w_rem_nx;
  logic [15:0] w_quot_nx;
  logic        w_ovf_nx;
  logic [4:0]  w_unused;

  // The remainder never reaches 9 significant bits, so the top bit only
  // exists to carry the trial sign conceptually.
  assign w_unused = {INSTANCE_ID, r_rem[8]};

  assign w_accept  = (r_state == S_IDLE) && i_valid;
  assign w_last    = (r_state == S_CALC) && (r_cnt == 5'd15);
  assign w_rem_sh  = {r_rem[7:0], r_quot[15]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b_q});
  assign w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, r_b_q}) : w_rem_sh;
  assign w_quot_nx = {r_quot[14:0], w_ge};
  assign w_ovf_nx  = |w_quot_nx[15:8];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_state_nx = (B == 8'd0) ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem     <= 9'd0;
      r_quot    <= 16'd0;
      r_cnt     <= 5'd0;
      r_b_q     <= 8'd0;
      r_a_final <= 8'd0;
      r_r_final <= 8'd0;
      r_ovf     <= 1'b0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      if (B == 8'd0) begin
        r_a_final <= 8'hFF;
        r_r_final <= 8'h00;
        r_ovf     <= 1'b0;
        r_dbz     <= 1'b1;
      end else begin
        r_rem  <= 9'd0;
        r_quot <= Z;
        r_b_q  <= B;
        r_cnt  <= 5'd0;
      end
    end else if (r_state == S_CALC) begin
      r_rem  <= w_rem_nx;
      r_quot <= w_quot_nx;
      r_cnt  <= r_cnt + 5'd1;
      if (w_last) begin
        r_ovf     <= w_ovf_nx;
        r_a_final <= w_ovf_nx ? 8'hFF : w_quot_nx[7:0];
        r_r_final <= w_rem_nx[7:0];
        r_dbz     <= 1'b0;
      end
    end
  end

  assign i_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign A_final = r_a_final;
  assign R_final = r_r_final;
  assign ovf     = r_ovf;
  assign dbz     = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_array_divider.sv
// ============================================================================
// Module   : tb_array_divider
// Purpose  : Directed self-checking bench for array_divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_divider;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] Z;
  logic [7:0]  B;
  logic [7:0]  A_final;
  logic [7:0]  R_final;
  logic        ovf;
  logic        dbz;
  logic        o_valid;

  int n_checks;
  int n_pass;

  array_divider #(.INSTANCE_ID(4'd1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .Z       (Z),
    .B       (B),
    .A_final (A_final),
    .R_final (R_final),
    .ovf     (ovf),
    .dbz     (dbz),
    .o_valid (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation from IDLE; returns cycles from accept edge to o_valid.
  task automatic run_op(input logic [15:0] z, input logic [7:0] b, output int lat);
    Z = z; B = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; Z = 16'd0; B = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if ({i_ready, o_valid, A_final, R_final, ovf, dbz} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_state: got rdy=%b vld=%b A=%h R=%h ovf=%b dbz=%b, want rdy=1 vld=0 A=00 R=00 ovf=0 dbz=0",
               i_ready, o_valid, A_final, R_final, ovf, dbz);
    else n_pass++;
  endtask

  task automatic test_exact_inverse();
    int lat;
    run_op(16'd65025, 8'd255, lat);
    n_checks++;
    if (lat !== 16 || o_valid !== 1'b1)
      $display("FAIL inverse_latency: got %0d (vld=%b), want 16", lat, o_valid);
    else n_pass++;
    n_checks++;
    if ({A_final, R_final, ovf, dbz} !== {8'd255, 8'd0, 1'b0, 1'b0})
      $display("FAIL inverse_result: got A=%0d R=%0d ovf=%b dbz=%b, want A=255 R=0 ovf=0 dbz=0",
               A_final, R_final, ovf, dbz);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1)
      $display("FAIL inverse_pulse_width: got vld=%b rdy=%b, want vld=0 rdy=1", o_valid, i_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    Z = 16'd512; B = 8'd3; i_valid = 1'b1;
    @(posedge clk); #1;
    Z = 16'd225; B = 8'd15;
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk); #1;
      if (c == 16) begin
        n_checks++;
        if ({o_valid, A_final, R_final} !== {1'b1, 8'd170, 8'd2})
          $display("FAIL rem_512_3: got vld=%b A=%0d R=%0d, want vld=1 A=170 R=2", o_valid, A_final, R_final);
        else n_pass++;
      end
      if (c == 17) begin
        n_checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0)
          $display("FAIL b2b_idle: got rdy=%b vld=%b, want rdy=1 vld=0", i_ready, o_valid);
        else n_pass++;
      end
      if (c == 18) begin
        n_checks++;
        if (i_ready !== 1'b0)
          $display("FAIL b2b_accept: got rdy=%b, want 0 (second op accepted)", i_ready);
        else n_pass++;
        i_valid = 1'b0;
      end
      if (c == 34) begin
        n_checks++;
        if ({o_valid, A_final, R_final, ovf} !== {1'b1, 8'd15, 8'd0, 1'b0})
          $display("FAIL b2b_225_15: got vld=%b A=%0d R=%0d ovf=%b, want vld=1 A=15 R=0 ovf=0",
                   o_valid, A_final, R_final, ovf);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [15:0] zs [3] = '{16'd65535, 16'd256, 16'd255};
    logic [17:0] exp [3] = '{{1'b1, 8'hFF, 8'd0, 1'b0}, {1'b1, 8'hFF, 8'd0, 1'b0}, {1'b0, 8'd255, 8'd0, 1'b0}};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(zs[k], 8'd1, lat);
      n_checks++;
      if (lat !== 16 || {ovf, A_final, R_final, dbz} !== exp[k])
        $display("FAIL ovf_%0d_by_1: got lat=%0d ovf=%b A=%h R=%h dbz=%b, want lat=16 {ovf,A,R,dbz}=%h",
                 zs[k], lat, ovf, A_final, R_final, dbz, exp[k]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_divide_by_zero();
    int lat;
    run_op(16'd1000, 8'd0, lat);
    n_checks++;
    if (lat !== 0 || {o_valid, dbz, ovf, A_final, R_final} !== {1'b1, 1'b1, 1'b0, 8'hFF, 8'h00})
      $display("FAIL dbz_result: got lat=%0d vld=%b dbz=%b ovf=%b A=%h R=%h, want lat=0 vld=1 dbz=1 ovf=0 A=ff R=00",
               lat, o_valid, dbz, ovf, A_final, R_final);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0 || dbz !== 1'b1)
      $display("FAIL dbz_recover: got rdy=%b vld=%b dbz=%b, want rdy=1 vld=0 dbz=1 (held)", i_ready, o_valid, dbz);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    int lat;
    Z = 16'd65025; B = 8'd255; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({i_ready, o_valid, A_final, R_final, ovf, dbz} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0})
      $display("FAIL midrst_state: got rdy=%b vld=%b A=%h R=%h ovf=%b dbz=%b, want rdy=1 vld=0 A=00 R=00 ovf=0 dbz=0",
               i_ready, o_valid, A_final, R_final, ovf, dbz);
    else n_pass++;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0)
      $display("FAIL midrst_no_valid: got %0d o_valid cycles, want 0", pulses);
    else n_pass++;
    run_op(16'd4, 8'd2, lat);
    n_checks++;
    if (lat !== 16 || {A_final, R_final} !== {8'd2, 8'd0})
      $display("FAIL midrst_fresh_4_2: got lat=%0d A=%0d R=%0d, want lat=16 A=2 R=0", lat, A_final, R_final);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_vs_valid();
    Z = 16'd50; B = 8'd5; i_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    n_checks++;
    if (i_ready !== 1'b1)
      $display("FAIL rst_beats_valid: got rdy=%b, want 1 (nothing accepted)", i_ready);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int pulses;
    logic [7:0] a_seen;
    logic [7:0] r_seen;
    Z = 16'd200; B = 8'd7; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    pulses = 0; a_seen = 8'h00; r_seen = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4) begin Z = 16'd100; B = 8'd10; i_valid = 1'b1; end
      if (c == 5) i_valid = 1'b0;
      @(posedge clk); #1;
      if (o_valid) begin
        pulses++;
        a_seen = A_final;
        r_seen = R_final;
      end
    end
    n_checks++;
    if (pulses !== 1)
      $display("FAIL busy_pulse_count: got %0d o_valid cycles, want 1", pulses);
    else n_pass++;
    n_checks++;
    if ({a_seen, r_seen} !== {8'd28, 8'd4})
      $display("FAIL busy_result_200_7: got A=%0d R=%0d, want A=28 R=4", a_seen, r_seen);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_exact_inverse();
    test_back_to_back();
    test_overflow();
    test_divide_by_zero();
    test_reset_mid_op();
    test_reset_vs_valid();
    test_busy_ignore();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
